// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file:
//   - wop_e        : write-operation encodings carried on WOP
//   - addr_class_e : classification of an address (general / zero / illegal)
//   - classify_addr: maps an address to its class for a given NREG and AW
// -----------------------------------------------------------------------------
package rf_pkg;

   typedef enum logic [1:0] {
      WOP_LOAD = 2'b00,
      WOP_INC  = 2'b01,
      WOP_DEC  = 2'b10,
      WOP_CLR  = 2'b11
   } wop_e;

   typedef enum logic [1:0] {
      ADDR_GENERAL = 2'b00,
      ADDR_ZERO    = 2'b01,
      ADDR_ILLEGAL = 2'b10
   } addr_class_e;

   // The top address (all ones) is the hard-wired zero register; it is tested
   // first so it can never be mistaken for a general or illegal address.
   function automatic addr_class_e classify_addr(input int unsigned addr,
                                                 input int unsigned nreg,
                                                 input int unsigned aw);
      int unsigned zero_addr;
      zero_addr = (32'd1 << aw) - 32'd1;
      if (addr == zero_addr) begin
         return ADDR_ZERO;
      end else if (addr < nreg) begin
         return ADDR_GENERAL;
      end else begin
         return ADDR_ILLEGAL;
      end
   endfunction

endpackage

// File: rtl/rf_next_val.sv
// -----------------------------------------------------------------------------
// rf_next_val
// Combinational next-value calculator for one register.
// Ports:
//   cur_i  in  WIDTH  current register value
//   wop_i  in  wop_e  write operation (load / inc / dec / clear)
//   in_i   in  WIDTH  load data
//   nxt_o  out WIDTH  value the register takes if the operation executes
// Increment and decrement wrap modulo 2**WIDTH; no carry or borrow is kept.
// -----------------------------------------------------------------------------
module rf_next_val
   import rf_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur_i,
   input  wop_e             wop_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] nxt_o
);

   always_comb begin
      case (wop_i)
         WOP_LOAD: nxt_o = in_i;
         WOP_INC:  nxt_o = cur_i + WIDTH'(1);
         WOP_DEC:  nxt_o = cur_i - WIDTH'(1);
         default:  nxt_o = '0;
      endcase
   end

endmodule

// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
// NREG general registers of WIDTH bits plus a hard-wired zero register at the
// top address. One write port (load / increment / decrement / clear all) and
// two registered read ports with write-first forwarding.
// Ports:
//   CLK      in  1      clock, rising edge
//   RST      in  1      asynchronous active-high reset
//   WE       in  1      write strobe
//   WOP      in  2      write operation (see rf_pkg::wop_e)
//   WADDR    in  AW     write address (ignored for clear all)
//   IN       in  WIDTH  load data
//   RADDR_A  in  AW     read address, port A
//   RADDR_B  in  AW     read address, port B
//   OUT_A    out WIDTH  registered read data, port A
//   OUT_B    out WIDTH  registered read data, port B
//   ERR      out 1      registered one-cycle illegal-address pulse
// -----------------------------------------------------------------------------
module reg_file_param
   import rf_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREG  = 3,
   parameter int unsigned AW    = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WE,
   input  logic [1:0]       WOP,
   input  logic [AW-1:0]    WADDR,
   input  logic [WIDTH-1:0] IN,
   input  logic [AW-1:0]    RADDR_A,
   input  logic [AW-1:0]    RADDR_B,
   output logic [WIDTH-1:0] OUT_A,
   output logic [WIDTH-1:0] OUT_B,
   output logic             ERR
);

   // The zero register occupies the top address, so at most 2**AW-1 general
   // registers fit in the address space.
   if (WIDTH < 1 || NREG < 1 || NREG > (2**AW) - 1) begin : g_bad_params
      $error("reg_file_param: need WIDTH>=1 and 1 <= NREG <= 2**AW-1");
   end

   wop_e             wop;
   addr_class_e      wcls, acls, bcls;
   logic             wr_gen, wr_clr;
   logic [WIDTH-1:0] cur_val, nxt_val;

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic             err_q, err_d;

   assign wop  = wop_e'(WOP);
   assign wcls = classify_addr(32'(WADDR),   NREG, AW);
   assign acls = classify_addr(32'(RADDR_A), NREG, AW);
   assign bcls = classify_addr(32'(RADDR_B), NREG, AW);

   assign wr_clr = WE && (wop == WOP_CLR);
   assign wr_gen = WE && (wop != WOP_CLR) && (wcls == ADDR_GENERAL);

   // Current value of the write target; zero/illegal targets never reach the
   // array, so their value is irrelevant.
   // NOTE: every signal driven in always_comb gets a default before any
   // conditional assignment, otherwise a latch is inferred.
   always_comb begin
      cur_val = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (WADDR == AW'(i)) begin
            cur_val = regs_q[i];
         end
      end
   end

   rf_next_val #(
      .WIDTH (WIDTH)
   ) u_next_val (
      .cur_i (cur_val),
      .wop_i (wop),
      .in_i  (IN),
      .nxt_o (nxt_val)
   );

   // Post-write image of the whole array. Clear all reaches every entry in
   // the same cycle; a dropped (illegal or zero-register) write leaves all
   // entries untouched.
   always_comb begin
      for (int i = 0; i < int'(NREG); i++) begin
         if (wr_clr) begin
            regs_d[i] = '0;
         end else if (wr_gen && (WADDR == AW'(i))) begin
            regs_d[i] = nxt_val;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Reads select from the post-write image, which gives write-first
   // forwarding. Zero-register and illegal addresses match no entry and
   // fall through to 0.
   always_comb begin
      out_a_d = '0;
      out_b_d = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (RADDR_A == AW'(i)) begin
            out_a_d = regs_d[i];
         end
         if (RADDR_B == AW'(i)) begin
            out_b_d = regs_d[i];
         end
      end
   end

   // Clear all never flags, whatever WADDR holds.
   assign err_d = (WE && (wop != WOP_CLR) && (wcls == ADDR_ILLEGAL))
                || (acls == ADDR_ILLEGAL)
                || (bcls == ADDR_ILLEGAL);

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the register array is built from flops (not RAM) and is reset
   // entry by entry, because reset and clear all must both reach every
   // entry at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
         out_a_q <= '0;
         out_b_q <= '0;
         err_q   <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
         err_q   <= err_d;
      end
   end

   assign OUT_A = out_a_q;
   assign OUT_B = out_b_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
// Drives two register files from the same stimulus: one with the default
// NREG=3/AW=2 map and one with NREG=2/AW=2, where address 2 is illegal.
// A bench-side model predicts both files' outputs per cycle into a queue;
// each scenario task then compares those predictions with the captured
// outputs.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

   typedef struct packed {
      logic [7:0] a3;
      logic [7:0] b3;
      logic       e3;
      logic [7:0] a2;
      logic [7:0] b2;
      logic       e2;
   } obs_t;

   logic       CLK, RST, WE;
   logic [1:0] WOP, WADDR, RADDR_A, RADDR_B;
   logic [7:0] IN;
   logic [7:0] out_a3, out_b3, out_a2, out_b2;
   logic       err3, err2;

   int checks = 0;
   int errors = 0;

   obs_t exp_q[$];
   obs_t obs_q[$];

   // Model state: m[0] mirrors the NREG=3 file, m[1] the NREG=2 file.
   logic [7:0] m [2][3];

   reg_file_param #(.WIDTH(8), .NREG(3), .AW(2)) dut3 (
      .CLK(CLK), .RST(RST), .WE(WE), .WOP(WOP), .WADDR(WADDR), .IN(IN),
      .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
      .OUT_A(out_a3), .OUT_B(out_b3), .ERR(err3)
   );

   reg_file_param #(.WIDTH(8), .NREG(2), .AW(2)) dut2 (
      .CLK(CLK), .RST(RST), .WE(WE), .WOP(WOP), .WADDR(WADDR), .IN(IN),
      .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
      .OUT_A(out_a2), .OUT_B(out_b2), .ERR(err2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 3; i++)
            m[k][i] = 8'h00;
   endtask

   // Drive one cycle, predict its outputs, clock it, capture the outputs.
   task automatic step(input logic we, input logic [1:0] wop,
                       input logic [1:0] wa, input logic [7:0] din,
                       input logic [1:0] ra, input logic [1:0] rb);
      obs_t e, o;
      logic [7:0] va [2];
      logic [7:0] vb [2];
      logic       ve [2];
      int nr;
      WE = we; WOP = wop; WADDR = wa; IN = din; RADDR_A = ra; RADDR_B = rb;
      for (int k = 0; k < 2; k++) begin
         nr = (k == 0) ? 3 : 2;
         if (we && wop == 2'b11) begin
            for (int i = 0; i < 3; i++) m[k][i] = 8'h00;
         end else if (we && int'(wa) < nr) begin
            case (wop)
               2'b00:   m[k][wa] = din;
               2'b01:   m[k][wa] = m[k][wa] + 8'd1;
               default: m[k][wa] = m[k][wa] - 8'd1;
            endcase
         end
         va[k] = (int'(ra) < nr) ? m[k][ra] : 8'h00;
         vb[k] = (int'(rb) < nr) ? m[k][rb] : 8'h00;
         ve[k] = (we && wop != 2'b11 && wa != 2'd3 && int'(wa) >= nr)
               || (ra != 2'd3 && int'(ra) >= nr)
               || (rb != 2'd3 && int'(rb) >= nr);
      end
      e.a3 = va[0]; e.b3 = vb[0]; e.e3 = ve[0];
      e.a2 = va[1]; e.b2 = vb[1]; e.e2 = ve[1];
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      o.a3 = out_a3; o.b3 = out_b3; o.e3 = err3;
      o.a2 = out_a2; o.b2 = out_b2; o.e2 = err2;
      obs_q.push_back(o);
   endtask

   task automatic test_reset();
      obs_t e, o;
      RST = 1'b1;
      WE = 1'b0; WOP = 2'b00; WADDR = 2'd0; IN = 8'h00;
      RADDR_A = 2'd0; RADDR_B = 2'd0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({out_a3, out_b3, err3, out_a2, out_b2, err2} !== 34'd0) begin
         errors++;
         $display("FAIL reset_initial: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want all 0",
                  out_a3, out_b3, err3, out_a2, out_b2, err2);
      end
      RST = 1'b0;
      step(1'b1, 2'b00, 2'd1, 8'h5A, 2'd1, 2'd2);
      // Mid-cycle reset with a write in flight.
      RST = 1'b1;
      WE = 1'b1; WOP = 2'b00; WADDR = 2'd1; IN = 8'hEE;
      #2;
      checks++;
      if ({out_a3, out_b3, err3, out_a2, out_b2, err2} !== 34'd0) begin
         errors++;
         $display("FAIL reset_async: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want all 0",
                  out_a3, out_b3, err3, out_a2, out_b2, err2);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd1, 2'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   task automatic test_load_forward();
      obs_t e, o;
      step(1'b1, 2'b00, 2'd1, 8'hA5, 2'd1, 2'd0);
      step(1'b1, 2'b00, 2'd0, 8'h3C, 2'd1, 2'd0);
      step(1'b0, 2'b00, 2'd0, 8'hFF, 2'd0, 2'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL load_forward: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   task automatic test_wrap();
      obs_t e, o;
      step(1'b1, 2'b00, 2'd0, 8'hFF, 2'd0, 2'd1);
      step(1'b1, 2'b01, 2'd0, 8'h00, 2'd0, 2'd1);
      step(1'b1, 2'b10, 2'd0, 8'h00, 2'd0, 2'd1);
      step(1'b1, 2'b00, 2'd0, 8'hFE, 2'd0, 2'd1);
      for (int n = 0; n < 3; n++) step(1'b1, 2'b01, 2'd0, 8'h00, 2'd0, 2'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   task automatic test_zero_reg();
      obs_t e, o;
      step(1'b1, 2'b00, 2'd3, 8'h77, 2'd3, 2'd3);
      step(1'b1, 2'b01, 2'd3, 8'h00, 2'd3, 2'd0);
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd0, 2'd1);
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd2, 2'd3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL zero_reg: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   task automatic test_illegal();
      obs_t e, o;
      // Address 2 is illegal only in the NREG=2 file.
      step(1'b1, 2'b00, 2'd2, 8'h99, 2'd0, 2'd2);
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd0, 2'd1);
      step(1'b1, 2'b01, 2'd2, 8'h00, 2'd1, 2'd0);
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd2, 2'd0);
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd0, 2'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL illegal: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   task automatic test_clear();
      obs_t e, o;
      step(1'b1, 2'b00, 2'd0, 8'h11, 2'd0, 2'd3);
      step(1'b1, 2'b00, 2'd1, 8'h22, 2'd1, 2'd0);
      step(1'b1, 2'b00, 2'd2, 8'h33, 2'd0, 2'd1);
      step(1'b1, 2'b11, 2'd2, 8'h5A, 2'd2, 2'd1);
      step(1'b1, 2'b00, 2'd1, 8'h44, 2'd1, 2'd0);
      step(1'b1, 2'b11, 2'd2, 8'h00, 2'd0, 2'd1);
      step(1'b0, 2'b00, 2'd0, 8'h00, 2'd2, 2'd3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL clear: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      step(1'b1, 2'b00, 2'd1, 8'hFD, 2'd1, 2'd1);
      for (int n = 0; n < 4; n++) step(1'b1, 2'b01, 2'd1, 8'h00, 2'd1, 2'd1);
      for (int n = 0; n < 2; n++) step(1'b1, 2'b10, 2'd1, 8'h00, 2'd1, 2'd0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back: got a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b want a3=%h b3=%h e3=%b a2=%h b2=%h e2=%b",
                     o.a3, o.b3, o.e3, o.a2, o.b2, o.e2, e.a3, e.b3, e.e3, e.a2, e.b2, e.e2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_forward();
      test_wrap();
      test_zero_reg();
      test_illegal();
      test_clear();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised successor to the team's 3-entry register file. It holds NREG general registers of WIDTH bits plus a hard-wired zero register, and has one write port with load, increment, decrement and clear-all operations. Two independent read ports have registered outputs and same-cycle write forwarding. It sits between the datapath ALU/input bus and the operand selectors, and flags illegal addresses.

## Interface
Parameters:
- WIDTH, 8, register and data width (≥1)
- NREG, 3, number of general registers (≥1)
- AW, 2, address width; required NREG ≤ 2**AW − 1 (elaboration error otherwise)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- WE  in  1  write strobe; operation WOP executes on the edge where WE=1
- WOP  in  2  write operation: 00 load IN, 01 increment, 10 decrement, 11 clear all
- WADDR  in  AW  write target (ignored for clear all)
- IN  in  WIDTH  load data
- RADDR_A  in  AW  read address, port A
- RADDR_B  in  AW  read address, port B
- OUT_A  out  WIDTH  registered read data, port A
- OUT_B  out  WIDTH  registered read data, port B
- ERR  out  1  registered one-cycle pulse: illegal address used this cycle

## Operation
- Address map:
  - 0..NREG−1: general registers R[i].
  - 2**AW−1: zero register, which always reads 0; writes to it are silently ignored with no ERR.
  - NREG..2**AW−2: illegal.
- Write ops (WE=1, legal general-register WADDR):
  - Load: R[WADDR] ← IN.
  - Increment: R ← R+1, modulo 2**WIDTH (all-ones wraps to 0).
  - Decrement: R ← R−1, modulo 2**WIDTH (0 wraps to all-ones).
  - No carry/borrow output.
- Clear all (WE=1, WOP=11): every R[i] ← 0 in one cycle, whatever WADDR is; never raises ERR.
- WE=0: registers hold. WOP, WADDR and IN are don't-care.
- Reads: every cycle, OUT_x ← value of register RADDR_x as it will be after this edge's write.
  - This is write-first forwarding: reading the register being written returns the new value (loaded, incremented, or 0 for clear all).
  - Zero-register and illegal read addresses return 0.
- ERR ← 1 for one cycle if any of these holds:
  - WE=1 with WOP≠11 and WADDR illegal. The write is dropped and no register changes.
  - RADDR_A illegal.
  - RADDR_B illegal.
- Both read ports may use the same address at once; each gets the identical value.

## Timing
- Reset (RST=1, asynchronous): all R[i]=0, OUT_A=0, OUT_B=0, ERR=0, held while RST is high.
- Reset mid-operation: the write in flight is discarded. The first edge with RST low operates normally.
- Read latency is 1 cycle: an address applied before edge n shows on OUT_x after edge n.
- Write-to-read: a write at edge n is visible on OUT_x at edge n when the addresses match (forwarded), and through normal reads afterwards.
- Back-to-back increments on one register every cycle are legal. Each edge adds exactly 1.
- ERR is asserted in the cycle after the offending inputs and is not sticky.
- No multicycle paths. The forwarding mux lies on the IN→OUT_x path within one cycle.

## Structure
- Shared package rf_pkg holds:
  - WOP encodings: WOP_LOAD=2'b00, WOP_INC=2'b01, WOP_DEC=2'b10, WOP_CLR=2'b11.
  - Address-classification helper: general / zero / illegal as a function of NREG and AW.
- One natural sub-module, rf_next_val. It is combinational: it computes the next value of a register from the current value, WOP and IN. It is instantiated once for the write path and reused by the forwarding logic.
- Register storage is an array of NREG WIDTH-bit registers. There is no RAM inference; clear all must reach every entry in one cycle.

## Test plan
- Reset: RST pulsed mid-cycle with R1=0x5A loaded → OUT_A, OUT_B and ERR are 0 immediately; a read of R1 after release gives 0x00.
- Load/forward: WE=1, WOP=00, WADDR=1, IN=0xA5, RADDR_A=1 in the same cycle → OUT_A=0xA5 after that edge. RADDR_B=0 → OUT_B=0x00.
- Wrap: load R0=0xFF, then increment → 0x00. Decrement → 0xFF. Three back-to-back increments from 0xFE → 0x01.
- Zero register: with AW=2 (address 3), load IN=0x77 to address 3 → ERR=0 and every read of address 3 returns 0x00. R0–R2 are unchanged.
- Illegal address: NREG=2, AW=2, load to WADDR=2 → ERR=1 for exactly one cycle and R0/R1 are unchanged. RADDR_B=2 → OUT_B=0x00 with ERR=1.
- Clear all: R0=0x11, R1=0x22, R2=0x33, then WOP=11 with RADDR_A=2 → OUT_A=0x00 after that edge, all registers read 0, ERR=0.
